vga_rect_fill: RTL and testbench

//  Hardware rectangle-fill engine feeding the VGA framebuffer pixel-write port (addr_x/addr_y/color/we).

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_rect_fill.sv | 139 +++++++++++++
 tb/tb_vga_rect_fill.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the framebuffer write-side blocks.
// Coordinates are unsigned; the _ext_t variant carries one extra bit so sums never wrap.
package vga_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned COLOR_W = 2;
    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } rect_fill_state_e;

    function automatic coord_ext_t min_ext(input coord_ext_t a, input coord_ext_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: turns one (x0, y0, w, h, colour) command into a raster-order
// stream of framebuffer pixel writes, one per clock, clipped to the visible area.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [COORD_W-1:0] cmd_x0_i,
    input  logic [COORD_W-1:0] cmd_y0_i,
    input  logic [COORD_W-1:0] cmd_w_i,
    input  logic [COORD_W-1:0] cmd_h_i,
    input  logic [COLOR_W-1:0] cmd_color_i,
    input  logic               abort_i,
    output logic [COORD_W-1:0] addr_x_o,
    output logic [COORD_W-1:0] addr_y_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               we_o,
    output logic               busy_o,
    output logic               done_o
);

    rect_fill_state_e state_q, state_d;
    coord_t           x_q, x_d;
    coord_t           y_q, y_d;
    coord_t           x0_q, x0_d;
    coord_ext_t       x_end_q, x_end_d;
    coord_ext_t       y_end_q, y_end_d;
    color_t           color_q, color_d;
    logic             we_q, we_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    coord_ext_t x_sum, y_sum;
    logic       cmd_empty;
    logic       last_col, last_row;

    // Extended-width sums so e.g. x0=2000, w=100 clips instead of wrapping.
    assign x_sum = {1'b0, cmd_x0_i} + {1'b0, cmd_w_i};
    assign y_sum = {1'b0, cmd_y0_i} + {1'b0, cmd_h_i};

    assign cmd_empty = (cmd_w_i == '0) || (cmd_h_i == '0) ||
                       ({1'b0, cmd_x0_i} >= coord_ext_t'(H_RES)) ||
                       ({1'b0, cmd_y0_i} >= coord_ext_t'(V_RES));

    assign last_col = ({1'b0, x_q} == (x_end_q - coord_ext_t'(1)));
    assign last_row = ({1'b0, y_q} == (y_end_q - coord_ext_t'(1)));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        color_d = color_q;
        we_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    x0_d    = cmd_x0_i;
                    x_d     = cmd_x0_i;
                    y_d     = cmd_y0_i;
                    color_d = cmd_color_i;
                    x_end_d = min_ext(x_sum, coord_ext_t'(H_RES));
                    y_end_d = min_ext(y_sum, coord_ext_t'(V_RES));
                    if (cmd_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        we_d    = 1'b1;
                    end
                end
            end
            FILL: begin
                // The pixel on the outputs this cycle is written even when aborting.
                if (abort_i || (last_col && last_row)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d = 1'b1;
                    if (last_col) begin
                        x_d = x0_q;
                        y_d = y_q + coord_t'(1);
                    end else begin
                        x_d = x_q + coord_t'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            color_q <= color_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign addr_x_o    = x_q;
    assign addr_y_o    = y_q;
    assign color_o     = color_q;
    assign we_o        = we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: expected pixel writes are queued when a command is
// driven and popped as the engine emits them; latencies and handshake levels are checked.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic   clk = 1'b0;
    logic   rst_i;
    logic   cmd_valid_i;
    logic   cmd_ready_o;
    coord_t cmd_x0_i, cmd_y0_i, cmd_w_i, cmd_h_i;
    color_t cmd_color_i;
    logic   abort_i;
    coord_t addr_x_o, addr_y_o;
    color_t color_o;
    logic   we_o, busy_o, done_o;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_x0_i    (cmd_x0_i),
        .cmd_y0_i    (cmd_y0_i),
        .cmd_w_i     (cmd_w_i),
        .cmd_h_i     (cmd_h_i),
        .cmd_color_i (cmd_color_i),
        .abort_i     (abort_i),
        .addr_x_o    (addr_x_o),
        .addr_y_o    (addr_y_o),
        .color_o     (color_o),
        .we_o        (we_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    typedef struct packed {
        coord_t x;
        coord_t y;
        color_t c;
    } px_t;

    px_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  n_writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; every write is scored.
    task automatic tick();
        px_t got, want;
        @(posedge clk);
        #1;
        if (we_o === 1'b1) begin
            n_writes++;
            chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = '{x: addr_x_o, y: addr_y_o, c: color_o};
                chk("pixel", 32'(got), 32'(want));
            end
        end
    endtask

    task automatic push_rect(input int x0, input int y0, input int w, input int h,
                             input int c, input int max_px);
        int xe, ye, n;
        xe = (x0 + w < int'(H_RES)) ? x0 + w : int'(H_RES);
        ye = (y0 + h < int'(V_RES)) ? y0 + h : int'(V_RES);
        n  = 0;
        for (int y = y0; y < ye; y++) begin
            for (int x = x0; x < xe; x++) begin
                if (n < max_px) exp_q.push_back('{x: coord_t'(x), y: coord_t'(y), c: color_t'(c)});
                n++;
            end
        end
    endtask

    // Returns after the accepting edge (sampled in cycle N+1); waited = cycles spent not ready.
    task automatic issue(input int x0, input int y0, input int w, input int h, input int c,
                         input int max_px, output int waited);
        logic acc;
        cmd_x0_i    = coord_t'(x0);
        cmd_y0_i    = coord_t'(y0);
        cmd_w_i     = coord_t'(w);
        cmd_h_i     = coord_t'(h);
        cmd_color_i = color_t'(c);
        cmd_valid_i = 1'b1;
        push_rect(x0, y0, w, h, c, max_px);
        waited = 0;
        forever begin
            acc = cmd_ready_o;
            tick();
            if (acc === 1'b1) break;
            waited++;
            if (waited > 500) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        cmd_valid_i = 1'b0;
    endtask

    // Counts ticks until done_o; then checks the one-cycle pulse and return to IDLE.
    task automatic wait_done(input int exp_ticks, input string tag);
        int c;
        c = 0;
        while (done_o !== 1'b1 && c < 2000) begin
            tick();
            c++;
        end
        chk({tag, "_done_latency"}, 32'(c), 32'(exp_ticks));
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
        chk({tag, "_not_ready_at_done"}, 32'(cmd_ready_o), 32'd0);
        chk({tag, "_no_we_at_done"}, 32'(we_o), 32'd0);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, "_ready_after_done"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, "_idle_not_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int waited, w0;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_x0_i    = '0;
        cmd_y0_i    = '0;
        cmd_w_i     = '0;
        cmd_h_i     = '0;
        cmd_color_i = '0;
        abort_i     = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_addr", 32'({addr_x_o, addr_y_o, color_o}), 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic 3x2 fill: done_o in cycle N+7
        w0 = n_writes;
        issue(10, 20, 3, 2, 2, 1000, waited);
        chk("basic_busy_in_fill", 32'(busy_o), 32'd1);
        wait_done(6, "basic");
        chk("basic_writes", 32'(n_writes - w0), 32'd6);

        // Clip at the bottom-right corner
        w0 = n_writes;
        issue(638, 479, 5, 4, 1, 1000, waited);
        wait_done(2, "clip");
        chk("clip_writes", 32'(n_writes - w0), 32'd2);

        // Empty: zero width, then off-screen origin, then huge origin that must not wrap
        w0 = n_writes;
        issue(5, 5, 0, 3, 3, 1000, waited);
        wait_done(0, "empty_w0");
        issue(640, 5, 4, 3, 3, 1000, waited);
        wait_done(0, "empty_x640");
        issue(2000, 10, 100, 1, 3, 1000, waited);
        wait_done(0, "empty_x2000");
        chk("empty_writes", 32'(n_writes - w0), 32'd0);

        // Abort with the 3rd pixel on the outputs
        w0 = n_writes;
        issue(0, 0, 4, 4, 3, 3, waited);
        tick();
        tick();
        abort_i = 1'b1;
        wait_done(1, "abort");
        abort_i = 1'b0;
        chk("abort_writes", 32'(n_writes - w0), 32'd3);

        // Back-to-back: second command held until the cycle after done_o
        w0 = n_writes;
        issue(10, 20, 3, 2, 1, 1000, waited);
        issue(100, 5, 2, 2, 3, 1000, waited);
        chk("b2b_wait_cycles", 32'(waited), 32'd7);
        wait_done(4, "b2b");
        chk("b2b_writes", 32'(n_writes - w0), 32'd10);

        // Reset mid-fill drops we_o, no done_o, command discarded
        issue(50, 60, 4, 4, 2, 2, waited);
        tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_we", 32'(we_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("midrst_done_after", 32'(done_o), 32'd0);
        chk("midrst_ready", 32'(cmd_ready_o), 32'd1);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
